// File: rtl/serial_frame_txrx.sv
// Full-duplex serial frame transceiver: start bit, 2*width_byte data bits LSB first, stop bit.
// Received words are accumulated into a saturating sum; loopback routes TX back into RX.
module serial_frame_txrx #(
  parameter int width_byte   = 8,
  parameter int words        = 8,
  parameter int clks_per_bit = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_rx_0,
  input  logic                            i_loopback,
  input  logic [2*width_byte-1:0]         i_tx_data,
  input  logic                            i_tx_valid,
  output logic                            o_tx_ready,
  output logic                            o_tx_0,
  output logic [2*width_byte-1:0]         o_rx_data,
  output logic                            o_rx_valid,
  output logic                            o_rx_err,
  output logic [2*width_byte+words-1:0]   o_sum
);

  localparam int DW = 2 * width_byte;
  localparam int SW = DW + words;
  localparam int CW = $clog2(clks_per_bit);
  localparam int BW = $clog2(DW);

  localparam logic [CW-1:0] BIT_LAST  = CW'(clks_per_bit - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(clks_per_bit / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Transmitter state
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  // Receiver state
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW:0]   sum_ext;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if (i_tx_valid) begin
          tx_state_d = ST_START;
          tx_shift_d = i_tx_data;
          tx_line_d  = 1'b0;
          tx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_state_d = ST_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Sum widened by one bit so the carry out signals saturation.
  assign sum_ext = {1'b0, sum_q} + (SW + 1)'(rx_shift_q);

  always_comb begin
    sync1_d    = i_loopback ? tx_line_q : i_rx_0;
    sync2_d    = sync1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    sum_d      = sum_q;
    case (rx_state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[DW-1:1]};
          if (rx_bit_q == DATA_LAST) rx_state_d = ST_STOP;
          else                       rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (sync2_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            sum_d      = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
          end else begin
            rx_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      sum_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      sum_q      <= sum_d;
    end
  end

  assign o_tx_ready = (tx_state_q == ST_IDLE);
  assign o_tx_0     = i_loopback | tx_line_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_err   = rx_err_q;
  assign o_sum      = sum_q;

endmodule

// File: tb/tb_serial_frame_txrx.sv
// Directed bench for serial_frame_txrx: TX waveform, loopback accumulation, framing
// errors, false starts, saturation and mid-frame reset.
module tb_serial_frame_txrx;

  localparam int WB  = 8;
  localparam int WDS = 1;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx_0;
  logic        i_loopback;
  logic [15:0] i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic        o_tx_0;
  logic [15:0] o_rx_data;
  logic        o_rx_valid;
  logic        o_rx_err;
  logic [16:0] o_sum;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int low_cnt   = 0;

  serial_frame_txrx #(.width_byte(WB), .words(WDS), .clks_per_bit(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_0     (i_rx_0),
    .i_loopback (i_loopback),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .o_tx_0     (o_tx_0),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_rx_err   (o_rx_err),
    .o_sum      (o_sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rx_valid) valid_cnt++;
    if (o_rx_err)   err_cnt++;
    if (!o_tx_0)    low_cnt++;
  end

  typedef struct {
    logic        do_reset;
    logic [15:0] word;
    logic [16:0] exp_sum;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rx_frame(input logic [15:0] w, input logic stop_bit, input int nbits);
    logic [17:0] f;
    f = {stop_bit, w, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      i_rx_0 = f[b];
      repeat (CPB) @(negedge clk);
    end
    i_rx_0 = 1'b1;
  endtask

  task automatic apply_vec(input int i);
    int v0, l0, n;
    if (vecs[i].do_reset) pulse_reset();
    i_loopback = 1'b1;
    n = 0;
    while (!o_tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("vec%0d_ready", i), 32'(o_tx_ready), 32'd1);
    v0 = valid_cnt;
    l0 = low_cnt;
    i_tx_data  = vecs[i].word;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
    i_tx_data  = ~vecs[i].word;
    n = 0;
    while (valid_cnt == v0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), 32'd1);
    check($sformatf("vec%0d_rx_data", i), 32'(o_rx_data), 32'(vecs[i].word));
    check($sformatf("vec%0d_sum", i), 32'(o_sum), 32'(vecs[i].exp_sum));
    check($sformatf("vec%0d_tx_pin_high", i), 32'(low_cnt - l0), 32'd0);
  endtask

  initial begin
    logic [17:0] f;
    int v0, e0, l0, bad_bits, bad_ready;

    vecs[0] = '{1'b0, 16'h1234, 17'h01234};
    vecs[1] = '{1'b0, 16'h0001, 17'h01235};
    vecs[2] = '{1'b0, 16'h00AA, 17'h000AA};
    vecs[3] = '{1'b1, 16'hFFFF, 17'h0FFFF};
    vecs[4] = '{1'b0, 16'hFFFF, 17'h1FFFE};
    vecs[5] = '{1'b0, 16'hFFFF, 17'h1FFFF};
    vecs[6] = '{1'b0, 16'hFFFF, 17'h1FFFF};

    rst        = 1'b0;
    i_rx_0     = 1'b1;
    i_loopback = 1'b0;
    i_tx_data  = '0;
    i_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_0", 32'(o_tx_0), 32'd1);
    check("rst_tx_ready", 32'(o_tx_ready), 32'd1);
    check("rst_rx_data", 32'(o_rx_data), 32'd0);
    check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    check("rst_rx_err", 32'(o_rx_err), 32'd0);
    check("rst_sum", 32'(o_sum), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // TX waveform: each frame bit held CPB cycles, ready low for one frame length
    f = {1'b1, 16'hA55A, 1'b0};
    bad_bits  = 0;
    bad_ready = 0;
    i_tx_data  = 16'hA55A;
    i_tx_valid = 1'b1;
    for (int k = 1; k <= 18 * CPB; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_tx_valid = 1'b0;
        i_tx_data  = 16'h0000;
      end
      if (o_tx_0 !== f[(k - 1) / CPB]) bad_bits++;
      if (o_tx_ready !== 1'b0) bad_ready++;
    end
    check("tx_shape_bad_cycles", 32'(bad_bits), 32'd0);
    check("tx_busy_ready_high_cycles", 32'(bad_ready), 32'd0);
    @(negedge clk);
    check("tx_ready_after_frame", 32'(o_tx_ready), 32'd1);
    check("tx_idle_line", 32'(o_tx_0), 32'd1);
    check("tx_no_rx_activity", 32'(valid_cnt + err_cnt), 32'd0);

    for (int i = 0; i < 2; i++) apply_vec(i);

    // Framing error: stop bit driven low
    i_loopback = 1'b0;
    repeat (4) @(negedge clk);
    v0 = valid_cnt;
    e0 = err_cnt;
    rx_frame(16'h00FF, 1'b0, 18);
    repeat (20) @(negedge clk);
    check("ferr_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_rx_data_kept", 32'(o_rx_data), 32'h0001);
    check("ferr_sum_kept", 32'(o_sum), 32'h01235);
    v0 = valid_cnt;
    e0 = err_cnt;
    rx_frame(16'h0003, 1'b1, 18);
    repeat (10) @(negedge clk);
    check("after_ferr_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_ferr_no_err", 32'(err_cnt - e0), 32'd0);
    check("after_ferr_rx_data", 32'(o_rx_data), 32'h0003);
    check("after_ferr_sum", 32'(o_sum), 32'h01238);

    // One-cycle glitch, then a frame right after the recovery window
    v0 = valid_cnt;
    e0 = err_cnt;
    i_rx_0 = 1'b0;
    @(negedge clk);
    i_rx_0 = 1'b1;
    repeat (CPB / 2 + 3) @(negedge clk);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
    rx_frame(16'h0F0F, 1'b1, 18);
    repeat (10) @(negedge clk);
    check("post_glitch_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_glitch_no_err", 32'(err_cnt - e0), 32'd0);
    check("post_glitch_rx_data", 32'(o_rx_data), 32'h0F0F);
    check("post_glitch_sum", 32'(o_sum), 32'h02147);

    // Reset halfway through concurrent TX and RX frames
    i_tx_data  = 16'h5555;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
    rx_frame(16'h3C3C, 1'b1, 9);
    v0 = valid_cnt;
    e0 = err_cnt;
    check("mid_tx_busy", 32'(o_tx_ready), 32'd0);
    pulse_reset();
    check("mid_rst_tx_0", 32'(o_tx_0), 32'd1);
    check("mid_rst_tx_ready", 32'(o_tx_ready), 32'd1);
    check("mid_rst_sum", 32'(o_sum), 32'd0);
    check("mid_rst_rx_data", 32'(o_rx_data), 32'd0);
    l0 = low_cnt;
    repeat (100) @(negedge clk);
    check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
    check("mid_rst_tx_quiet", 32'(low_cnt - l0), 32'd0);

    for (int i = 2; i < 7; i++) apply_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule

// File: doc/serial_frame_txrx.md
Name: serial_frame_txrx

Overview:
Parametrised full-duplex serial frame transceiver with the same interface style as the top-level serial block.
- Serialises parallel words of 2*width_byte bits onto o_tx_0 and deserialises frames arriving on i_rx_0.
- Keeps a saturating running sum of correctly received words.
- Adds an internal loopback mode for self-test.
- Sits between the core datapath and the board-level serial pins.

Parameters:
width_byte, 8, byte width; frame payload is 2*width_byte bits.
words, 8, extra accumulator headroom bits; o_sum is 2*width_byte+words bits.
clks_per_bit, 16, clk cycles per serial bit; must be even and >= 4.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
i_rx_0  input  1  serial receive line; asynchronous, idle high.
i_loopback  input  1  1 = RX fed from the internal TX line and o_tx_0 held high.
i_tx_data  input  2*width_byte  word to transmit.
i_tx_valid  input  1  transmit request.
o_tx_ready  output  1  high when the transmitter is idle and will accept a word.
o_tx_0  output  1  serial transmit line; idle high.
o_rx_data  output  2*width_byte  last correctly received word.
o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
o_rx_err  output  1  one-cycle pulse on a framing error.
o_sum  output  2*width_byte+words  saturating sum of received words.

Behaviour:
- Frame format: 1 start bit (0), 2*width_byte data bits LSB first, 1 stop bit (1). Each bit lasts clks_per_bit cycles; one frame is (2*width_byte+2)*clks_per_bit cycles.
- Reset (rst=0 at a clk edge): TX and RX FSMs go to IDLE, all counters clear.
  - Output values: o_tx_0=1, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_rx_err=0, o_sum=0, synchronizer flops=1.
  - Reset mid-frame aborts the frame with no pulse and no sum update.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Handshake: the word is accepted on the edge where i_tx_valid=1 and o_tx_ready=1. o_tx_ready is 1 only in IDLE.
  - o_tx_0 drives the start bit (0) from the cycle after acceptance.
  - o_tx_ready returns to 1 exactly one frame length after acceptance.
  - i_tx_valid while busy is ignored; there is no queueing.
  - i_tx_data is captured at acceptance; later changes to it have no effect.
- RX path input: 2-flop synchronizer on the selected RX source. The source is i_rx_0, or the internal TX line when i_loopback=1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized low enters START.
  - START: after clks_per_bit/2 cycles, resample. If the line is high it is a false start: return to IDLE with no pulse.
  - DATA: sample every clks_per_bit cycles thereafter, mid-bit, for 2*width_byte bits.
  - STOP: sample the stop bit, then return to IDLE.
- Stop bit = 1:
  - Update o_rx_data and pulse o_rx_valid for 1 cycle.
  - On that same edge, o_sum <= min(o_sum + o_rx_data_new, all-ones). Saturation holds until reset.
- Stop bit = 0: pulse o_rx_err for 1 cycle; o_rx_data and o_sum are unchanged.
- The RX FSM rearms in IDLE the cycle after the stop sample. Back-to-back frames are received without loss.
- Loopback:
  - i_loopback is sampled continuously.
  - Toggling it mid-frame may corrupt that frame (the error is flagged via stop check or false start), but must never hang either FSM.
  - With i_loopback=1, o_tx_0 is held at 1 while the internal TX line still sequences.
- TX and RX are fully independent; simultaneous TX accept and RX completion on the same edge are both honoured.

Test Plan:
- TX shape (width_byte=8, clks_per_bit=4): accept 0xA55A -> o_tx_0 sequence is 0, then 0,1,0,1,1,0,1,0, 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles; o_tx_ready=0 for exactly 72 cycles.
- Loopback accumulate: i_loopback=1, send 0x1234 then 0x0001 -> o_rx_valid pulses twice; o_rx_data 0x1234 then 0x0001; o_sum 0x1234 then 0x1235; o_tx_0 stays 1 throughout.
- Framing error: drive a valid frame 0x00FF on i_rx_0 with stop bit 0 -> one o_rx_err pulse; o_rx_valid stays 0; o_rx_data and o_sum unchanged. The next valid frame 0x0003 is received normally.
- False start and glitch: 1-cycle low pulse on i_rx_0 -> no o_rx_valid, no o_rx_err; RX returns to IDLE within clks_per_bit/2+3 cycles.
- Saturation (words=1): receive 0xFFFF three times -> o_sum reads 0x0FFFF, 0x1FFFE, 0x1FFFF, and stays at 0x1FFFF after a fourth frame.
- Reset mid-frame: assert rst=0 for 1 cycle halfway through TX and RX frames -> o_tx_0=1, o_tx_ready=1, o_sum=0 on the next edge, no pulses. A new 0x00AA transfer afterwards completes correctly.
